// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Accepts one operation per in_valid/in_ready handshake and returns the
// result on an out_valid/out_ready handshake. Only one operation is in flight.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds its payload stable while
// valid && !ready, and ready never depends combinationally on valid.
//
// Flow: IDLE -> CALC (WIDTH iterations) -> FIX (sign correction) -> DONE.
// Divide by zero and signed overflow skip straight from IDLE to DONE.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    // Latched operation context
    logic [2:0]         op;
    logic [WIDTH-1:0]   ma;      // multiplicand magnitude
    logic [WIDTH-1:0]   mq;      // multiplier (shifts right) or divisor magnitude
    logic               neg;     // negate the selected result in FIX
    logic [CW-1:0]      cnt;
    // Multiply: 2*WIDTH product. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;

    // Accept-time decode
    logic               accept;
    logic               a_signed, b_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_in;
    logic               fast_zero, fast_ovf, fast;
    logic [WIDTH-1:0]   fast_result;

    // Iteration step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Sign fix-up
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        dbg_state = state;
    end

    // Operand decode at the accept edge: signedness, magnitudes, fast path
    always_comb begin
        accept   = in_valid && (state == S_IDLE);
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && A[WIDTH-1];
        b_neg    = b_signed && B[WIDTH-1];
        a_mag    = a_neg ? (~A + 1'b1) : A;
        b_mag    = b_neg ? (~B + 1'b1) : B;
        // REM follows the dividend sign; every other signed op uses sign XOR.
        neg_in   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

        fast_zero = funct3[2] && (B == '0);
        fast_ovf  = funct3[2] && !funct3[0] &&
                    (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        fast      = fast_zero || fast_ovf;

        fast_result = '0;
        if (fast_zero) begin
            fast_result = funct3[1] ? A : '1;
        end else if (fast_ovf) begin
            fast_result = funct3[1] ? '0 : A;
        end
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mq[0] ? ma : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mq};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix = neg ? (~acc + 1'b1) : acc;
        quo_fix  = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 fix_result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Datapath registers: latch on accept, iterate in CALC, load Out in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            op  <= '0;
            ma  <= '0;
            mq  <= '0;
            neg <= 1'b0;
            cnt <= '0;
            acc <= '0;
            Out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op  <= funct3;
                        ma  <= a_mag;
                        mq  <= b_mag;
                        neg <= neg_in;
                        cnt <= '0;
                        // Divide keeps the dividend in the low half; it shifts
                        // out as quotient bits shift in.
                        acc <= funct3[2] ? {{WIDTH{1'b0}}, a_mag} : '0;
                        if (fast) begin
                            Out <= fast_result;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        acc <= div_next;
                    end else begin
                        acc <= mul_next;
                        mq  <= mq >> 1;
                    end
                end
                S_FIX: begin
                    Out <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
